// File: rtl/logic_bist_pkg.sv
// Shared types and the golden operation for the logic BIST engine.
package logic_bist_pkg;

  // Widest operand the golden function handles; callers cast down to their width.
  localparam int unsigned MaxW = 32;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  function automatic logic [MaxW-1:0] golden_op(mode_e mode, logic [MaxW-1:0] a,
                                                 logic [MaxW-1:0] b);
    logic [MaxW-1:0] res;
    res = '0;
    unique case (mode)
      MODE_AND:  res = a & b;
      MODE_OR:   res = a | b;
      MODE_XOR:  res = a ^ b;
      MODE_NAND: res = ~(a & b);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_bist_if.sv
// Control, operand and result signals between the BIST engine and its user.
interface logic_bist_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 16
) ();
  import logic_bist_pkg::*;

  logic                 Start;
  mode_e                Mode;
  logic [WIDTH-1:0]     In0;
  logic [WIDTH-1:0]     In1;
  logic [WIDTH-1:0]     DutOut;
  logic                 Busy;
  logic                 Done;
  logic                 Pass;
  logic [ERR_W-1:0]     ErrCnt;
  logic [2*WIDTH-1:0]   FirstFailIdx;

  // Controller / DUT harness side.
  modport master (
    output Start, Mode, DutOut,
    input  In0, In1, Busy, Done, Pass, ErrCnt, FirstFailIdx
  );

  // BIST engine side.
  modport slave (
    input  Start, Mode, DutOut,
    output In0, In1, Busy, Done, Pass, ErrCnt, FirstFailIdx
  );

endinterface

// File: rtl/bist_delay_line.sv
// Valid-tagged shift register aligning expected values with a pipelined DUT.
module bist_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Combinational DUT: nothing to delay.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
    end else begin : g_shift
      logic [DEPTH-1:0] vld_q;
      logic [W-1:0]     dat_q [DEPTH];

      // Shift valid tag and payload one stage per cycle; reset empties the line.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
          vld_q[0] <= in_valid;
          dat_q[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      end

      assign out_valid = vld_q[DEPTH-1];
      assign out_data  = dat_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/logic_bist.sv
// Exhaustive-sweep self-test engine for 2-input bitwise logic blocks.
module logic_bist
  import logic_bist_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned LATENCY = 0,
  parameter int unsigned ERR_W   = 16
) (
  input logic         Clk,
  input logic         Rst,
  logic_bist_if.slave bus
);

  localparam int unsigned PatW   = 2 * WIDTH;
  localparam int unsigned DlW    = WIDTH + PatW;
  localparam int unsigned DrainW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              state_q, state_d;
  logic [PatW-1:0]     pat_q;
  mode_e               mode_q;
  logic [DrainW-1:0]   drain_q;
  logic [ERR_W-1:0]    err_q;
  logic [PatW-1:0]     ff_q;
  logic                ff_seen_q;

  logic                start_ok;
  logic                last_pat;
  logic                drain_last;
  logic [WIDTH-1:0]    exp_now;
  logic [WIDTH-1:0]    exp_dl;
  logic [PatW-1:0]     idx_dl;
  logic [DlW-1:0]      dl_out;
  logic                vld_dl;
  logic                mismatch;

  assign last_pat   = (pat_q == '1);
  assign drain_last = (drain_q == DrainW'(LATENCY - 1));

  // Golden value is computed on the operands presented this cycle.
  assign exp_now = WIDTH'(golden_op(mode_q, MaxW'(pat_q[WIDTH-1:0]),
                                    MaxW'(pat_q[PatW-1:WIDTH])));

  bist_delay_line #(
    .DEPTH (LATENCY),
    .W     (DlW)
  ) u_delay (
    .clk       (Clk),
    .rst       (Rst),
    .in_valid  (state_q == StRun),
    .in_data   ({exp_now, pat_q}),
    .out_valid (vld_dl),
    .out_data  (dl_out)
  );

  assign exp_dl   = dl_out[DlW-1:PatW];
  assign idx_dl   = dl_out[PatW-1:0];
  assign mismatch = vld_dl && (bus.DutOut != exp_dl);

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state; Start only counts in IDLE or DONE.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.Start) begin
          state_d  = StRun;
          start_ok = 1'b1;
        end
      end
      StRun: begin
        if (last_pat) state_d = (LATENCY > 0) ? StDrain : StDone;
      end
      StDrain: begin
        if (drain_last) state_d = StDone;
      end
    endcase
  end

  // Pattern/drain counters, mode latch, error counter and first-fail capture.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pat_q     <= '0;
      mode_q    <= MODE_AND;
      drain_q   <= '0;
      err_q     <= '0;
      ff_q      <= '0;
      ff_seen_q <= 1'b0;
    end else if (start_ok) begin
      pat_q     <= '0;
      mode_q    <= bus.Mode;
      drain_q   <= '0;
      err_q     <= '0;
      ff_q      <= '0;
      ff_seen_q <= 1'b0;
    end else begin
      if (state_q == StRun && !last_pat) pat_q <= pat_q + PatW'(1);
      if (state_q == StDrain) drain_q <= drain_q + DrainW'(1);
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + ERR_W'(1);
        if (!ff_seen_q) begin
          ff_q      <= idx_dl;
          ff_seen_q <= 1'b1;
        end
      end
    end
  end

  assign bus.In0          = pat_q[WIDTH-1:0];
  assign bus.In1          = pat_q[PatW-1:WIDTH];
  assign bus.Busy         = (state_q == StRun) || (state_q == StDrain);
  assign bus.Done         = (state_q == StDone);
  assign bus.Pass         = (state_q == StDone) && (err_q == '0);
  assign bus.ErrCnt       = err_q;
  assign bus.FirstFailIdx = ff_q;

endmodule

// File: tb/tb_logic_bist.sv
// Bench for logic_bist: WIDTH=2 engines against combinational and 2-stage AND DUTs.
module tb_logic_bist;
  import logic_bist_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic fault;
  bit   mon_en;

  always #5 clk = ~clk;

  logic_bist_if #(.WIDTH(2), .ERR_W(16)) b0 ();
  logic_bist_if #(.WIDTH(2), .ERR_W(16)) b1 ();
  logic_bist_if #(.WIDTH(2), .ERR_W(16)) b2 ();
  logic_bist_if #(.WIDTH(2), .ERR_W(2))  b3 ();

  logic_bist #(.WIDTH(2), .LATENCY(0), .ERR_W(16)) u0 (.Clk(clk), .Rst(rst), .bus(b0));
  logic_bist #(.WIDTH(2), .LATENCY(1), .ERR_W(16)) u1 (.Clk(clk), .Rst(rst), .bus(b1));
  logic_bist #(.WIDTH(2), .LATENCY(2), .ERR_W(16)) u2 (.Clk(clk), .Rst(rst), .bus(b2));
  logic_bist #(.WIDTH(2), .LATENCY(0), .ERR_W(2))  u3 (.Clk(clk), .Rst(rst), .bus(b3));

  // DUT models: combinational AND (optional stuck-at-0 on bit 0), 2-stage registered AND.
  logic [1:0] p1_s1, p1_s2, p2_s1, p2_s2;
  always_comb b0.DutOut = (b0.In0 & b0.In1) & (fault ? 2'b10 : 2'b11);
  always_comb b3.DutOut = b3.In0 & b3.In1;
  always_ff @(posedge clk) begin
    p1_s1 <= b1.In0 & b1.In1;
    p1_s2 <= p1_s1;
    p2_s1 <= b2.In0 & b2.In1;
    p2_s2 <= p2_s1;
  end
  assign b1.DutOut = p1_s2;
  assign b2.DutOut = p2_s2;

  typedef struct {
    string name;
    mode_e mode;
    bit    fault;
    int    cycles;
    int    err;
    int    ff;
    bit    pass;
    bit    err_any;
    int    poke;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] pq[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic get(input int w, output int busy, output int done, output int pass,
                     output int err, output int ff, output int pat);
    case (w)
      0: begin
        busy = int'(b0.Busy); done = int'(b0.Done); pass = int'(b0.Pass);
        err = int'(b0.ErrCnt); ff = int'(b0.FirstFailIdx); pat = int'({b0.In1, b0.In0});
      end
      1: begin
        busy = int'(b1.Busy); done = int'(b1.Done); pass = int'(b1.Pass);
        err = int'(b1.ErrCnt); ff = int'(b1.FirstFailIdx); pat = int'({b1.In1, b1.In0});
      end
      2: begin
        busy = int'(b2.Busy); done = int'(b2.Done); pass = int'(b2.Pass);
        err = int'(b2.ErrCnt); ff = int'(b2.FirstFailIdx); pat = int'({b2.In1, b2.In0});
      end
      default: begin
        busy = int'(b3.Busy); done = int'(b3.Done); pass = int'(b3.Pass);
        err = int'(b3.ErrCnt); ff = int'(b3.FirstFailIdx); pat = int'({b3.In1, b3.In0});
      end
    endcase
  endtask

  task automatic set(input int w, input bit s, input mode_e m);
    case (w)
      0:       begin b0.Start = s; b0.Mode = m; end
      1:       begin b1.Start = s; b1.Mode = m; end
      2:       begin b2.Start = s; b2.Mode = m; end
      default: begin b3.Start = s; b3.Mode = m; end
    endcase
  endtask

  // One full sweep: expectations go to the scoreboard at Start, are popped at Done.
  task automatic run_sweep(input int w, input exp_t e);
    int   busy, done, pass, err, ff, pat, cyc;
    bit   busy_ok;
    exp_t got;
    sb.push_back(e);
    @(negedge clk);
    fault = e.fault;
    set(w, 1'b1, e.mode);
    if (w == 0 && mon_en) for (int i = 0; i < 16; i++) pq.push_back(4'(i));
    @(posedge clk);
    #1 set(w, 1'b0, e.mode);
    get(w, busy, done, pass, err, ff, pat);
    check({e.name, " busy_after_start"}, busy, 1);
    check({e.name, " err_cleared"}, err, 0);
    cyc = 0;
    busy_ok = 1'b1;
    done = 0;
    while (cyc < 200 && done == 0) begin
      if (e.poke != 0 && cyc + 1 == e.poke) set(w, 1'b1, MODE_NAND);
      @(posedge clk);
      cyc++;
      #1 set(w, 1'b0, e.mode);
      get(w, busy, done, pass, err, ff, pat);
      if (done == 0 && busy == 0) busy_ok = 1'b0;
    end
    got = sb.pop_front();
    check({got.name, " cycles_to_done"}, cyc, got.cycles);
    if (got.err_any) begin
      checks++;
      if (err == 0) begin
        errors++;
        $display("FAIL %s errcnt_nonzero: got %0d, expected >0", got.name, err);
      end
    end else begin
      check({got.name, " errcnt"}, err, got.err);
      check({got.name, " first_fail"}, ff, got.ff);
    end
    check({got.name, " pass"}, pass, int'(got.pass));
    check({got.name, " busy_at_done"}, busy, 0);
    check({got.name, " busy_through_sweep"}, int'(busy_ok), 1);
    @(posedge clk);
    #1 get(w, busy, done, pass, err, ff, pat);
    check({got.name, " done_holds"}, done, 1);
  endtask

  // Operand monitor for engine 0: each RUN cycle must present the next sweep pattern.
  always begin
    @(posedge clk);
    #1;
    if (mon_en && b0.Busy === 1'b1) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pattern_extra: got %0d, expected none", {b0.In1, b0.In0});
      end else begin
        check("pattern", int'({b0.In1, b0.In0}), int'(pq.pop_front()));
      end
    end
  end

  exp_t tbl[6];

  initial begin
    int busy, done, pass, err, ff, pat, cyc;
    exp_t e;

    tbl[0] = '{"and_clean_poke_run", MODE_AND,  1'b0, 16, 0,  0, 1'b1, 1'b0, 5};
    tbl[1] = '{"and_stuck0",         MODE_AND,  1'b1, 16, 4,  5, 1'b0, 1'b0, 0};
    tbl[2] = '{"xor_on_and",         MODE_XOR,  1'b0, 16, 15, 1, 1'b0, 1'b0, 0};
    tbl[3] = '{"or_on_and",          MODE_OR,   1'b0, 16, 12, 1, 1'b0, 1'b0, 0};
    tbl[4] = '{"nand_poke_done",     MODE_NAND, 1'b0, 16, 16, 0, 1'b0, 1'b0, 16};
    tbl[5] = '{"and_after_nand",     MODE_AND,  1'b0, 16, 0,  0, 1'b1, 1'b0, 0};

    mon_en = 1'b0;
    fault  = 1'b0;
    rst    = 1'b1;
    for (int w = 0; w < 4; w++) set(w, 1'b0, MODE_AND);
    repeat (3) @(posedge clk);
    #1 get(0, busy, done, pass, err, ff, pat);
    check("reset operands", pat, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset errcnt", err, 0);
    check("reset first_fail", ff, 0);
    @(negedge clk);
    rst = 1'b0;

    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) run_sweep(0, tbl[i]);

    e = '{"lat2_and", MODE_AND, 1'b0, 18, 0, 0, 1'b1, 1'b0, 0};
    run_sweep(2, e);
    e = '{"lat1_misaligned", MODE_AND, 1'b0, 17, 0, 0, 1'b0, 1'b1, 0};
    run_sweep(1, e);
    e = '{"errcnt_saturate", MODE_XOR, 1'b0, 16, 3, 1, 1'b0, 1'b0, 0};
    run_sweep(3, e);

    // Reset while pattern 7 is on the operands.
    mon_en = 1'b0;
    pq.delete();
    @(negedge clk);
    set(0, 1'b1, MODE_XOR);
    @(posedge clk);
    #1 set(0, 1'b0, MODE_XOR);
    cyc = 0;
    get(0, busy, done, pass, err, ff, pat);
    while (cyc < 40 && !(pat == 7 && busy == 1)) begin
      @(posedge clk);
      #1 get(0, busy, done, pass, err, ff, pat);
      cyc++;
    end
    check("reached pattern 7", pat, 7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 get(0, busy, done, pass, err, ff, pat);
    check("midrst operands", pat, 0);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst pass", pass, 0);
    check("midrst errcnt", err, 0);
    check("midrst first_fail", ff, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    e = '{"and_after_reset", MODE_AND, 1'b0, 16, 0, 0, 1'b1, 1'b0, 0};
    run_sweep(0, e);

    repeat (2) @(posedge clk);
    #1;
    check("pattern queue drained", pq.size(), 0);
    check("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
